// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// Optional early completion is enabled with SHIFT_SEQ_EARLY_DONE_EN.
package shift_pkg;

  localparam int WIDTH  = 32;
  localparam int NSTAGE = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // True when no shift amount bits remain below stage k.
  function automatic logic low_bits_zero(
    input logic [4:0] sh,
    input logic [2:0] k
  );
    logic [4:0] mask;
    mask = (5'd1 << k) - 5'd1;
    return (sh & mask) == 5'd0;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the execute stage and the shifter.
// Shared by the base and SHIFT_SEQ_EARLY_DONE_EN builds.
interface shift_sequencer_if;
  import shift_pkg::*;

  logic             in_start;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_A;
  logic [4:0]       in_shamt;
  logic [WIDTH-1:0] out_result;
  logic             out_valid;
  logic             out_busy;

  modport master (
    output in_start,
    output in_op,
    output in_A,
    output in_shamt,
    input  out_result,
    input  out_valid,
    input  out_busy
  );

  modport slave (
    input  in_start,
    input  in_op,
    input  in_A,
    input  in_shamt,
    output out_result,
    output out_valid,
    output out_busy
  );

endinterface

// File: rtl/shift_stage_var.sv
// One selectable barrel stage: shifts by 2^k when enabled.
// Identical in base and SHIFT_SEQ_EARLY_DONE_EN builds.
module shift_stage_var
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] acc_i,
  input  logic [2:0]       k_i,
  input  logic             en_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] acc_o
);

  logic [5:0] amt;

  assign amt = 6'd1 << k_i;

  // Unknown op codes fall back to a logical left shift.
  always_comb begin
    acc_o = acc_i;
    if (en_i) begin
      if (op_i == OP_SRA) begin
        acc_o = $unsigned($signed(acc_i) >>> amt);
      end else begin
        acc_o = acc_i << amt;
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequential SLL/SRA unit, one barrel stage (16,8,4,2,1) per cycle.
// SHIFT_SEQ_EARLY_DONE_EN ends the pass once no shamt bits remain.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       shamt_q;
  logic [1:0]       op_q;
  logic [2:0]       k_q;
  logic             valid_q;
  logic             busy_q;
  logic             last;

  shift_stage_var u_stage (
    .acc_i (acc_q),
    .k_i   (k_q),
    .en_i  (shamt_q[k_q]),
    .op_i  (op_q),
    .acc_o (acc_d)
  );

`ifdef SHIFT_SEQ_EARLY_DONE_EN
  assign last = low_bits_zero(shamt_q, k_q);
`else
  assign last = (k_q == 3'd0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      shamt_q  <= '0;
      op_q     <= OP_SLL;
      k_q      <= 3'(NSTAGE - 1);
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          valid_q <= 1'b0;
          if (bus.in_start) begin
            acc_q   <= bus.in_A;
            shamt_q <= bus.in_shamt;
            op_q    <= bus.in_op;
            k_q     <= 3'(NSTAGE - 1);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          if (last) begin
            result_q <= acc_d;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            k_q <= k_q - 3'd1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_result = result_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_busy   = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (result and valid timing).
// Expected latency follows SHIFT_SEQ_EARLY_DONE_EN when defined.
module tb_shift_sequencer;
  import shift_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  shift_sequencer_if bus();

  shift_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [4:0]  sh
  );
    logic [31:0] r;
    if (op == OP_SRA) r = $unsigned($signed(a) >>> sh);
    else              r = a << sh;
    return r;
  endfunction

  function automatic int lat(input logic [4:0] sh);
`ifdef SHIFT_SEQ_EARLY_DONE_EN
    int tz;
    tz = 0;
    while (tz < 4 && sh[tz] == 1'b0) tz++;
    return 5 - tz;
`else
    return 5 + 0 * int'(sh);
`endif
  endfunction

  always @(negedge clock) begin : mon
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("result", bus.out_result, e.res);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // Call either at negedge or just after a posedge.
  task automatic start_op(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [4:0]  sh
  );
    exp_t e;
    e.res = model(op, a, sh);
    e.cyc = cyc + 1 + lat(sh);
    bus.in_op    = op;
    bus.in_A     = a;
    bus.in_shamt = sh;
    bus.in_start = 1'b1;
    q.push_back(e);
    @(posedge clock);
    #1 bus.in_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(negedge clock);
    if (q.size() != 0) begin
      chk("timeout", q.size(), 0);
      q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got hang exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset        = 1'b1;
    bus.in_start = 1'b0;
    bus.in_op    = OP_SLL;
    bus.in_A     = '0;
    bus.in_shamt = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_result", bus.out_result, 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.out_busy), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    start_op(OP_SLL, 32'h12345678, 5'd4);
    chk("busy_in_shift", 32'(bus.out_busy), 32'd1);
    chk("hold_prev", bus.out_result, 32'h0);
    wait_done();
    chk("busy_after", 32'(bus.out_busy), 32'd0);

    start_op(OP_SLL, 32'h00000001, 5'd31); wait_done();
    start_op(OP_SRA, 32'h80000000, 5'd4);  wait_done();
    start_op(OP_SRA, 32'h7FFFFFFF, 5'd31); wait_done();
    start_op(2'b10,  32'h00000001, 5'd3);  wait_done();
    start_op(2'b11,  32'h80000001, 5'd2);  wait_done();
    start_op(OP_SLL, 32'hA5A5_0F0F, 5'd0); wait_done();
    start_op(OP_SRA, 32'h9000_0000, 5'd16); wait_done();
    start_op(OP_SRA, 32'hFFFF_FFFE, 5'd1); wait_done();
    for (int i = 0; i < 6; i++) begin
      start_op(2'($urandom_range(0, 1)), $urandom, 5'($urandom));
      wait_done();
    end

    // Second start while busy must be dropped.
    start_op(OP_SLL, 32'h0000000F, 5'd8);
    @(posedge clock);
    #1;
    bus.in_start = 1'b1;
    bus.in_op    = OP_SRA;
    bus.in_A     = 32'h00000001;
    bus.in_shamt = 5'd0;
    @(posedge clock);
    #1 bus.in_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    if (seen) begin
      start_op(OP_SRA, 32'hFFFF0000, 5'd16);
      chk("b2b_hold", bus.out_result, 32'h00000F00);
      chk("b2b_busy", 32'(bus.out_busy), 32'd1);
    end else begin
      chk("b2b_valid", 32'd0, 32'd1);
    end
    wait_done();

    // Reset sampled at E3 aborts the pass.
    start_op(OP_SLL, 32'hDEADBEEF, 5'd5);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    chk("abort_result", bus.out_result, 32'h0);
    chk("abort_busy", 32'(bus.out_busy), 32'd0);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    repeat (8) @(negedge clock);
    @(posedge clock);
    #1;

    start_op(OP_SRA, 32'h80000001, 5'd1);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
